// File: rtl/dvi_tx_video_timing_gen.sv
// Raster timing generator with built-in test patterns for the DVI transmit path.
// All outputs are registered from the current counter state, so they lag the counters by one clock.
module dvi_tx_video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        den,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    logic [11:0] h_cnt, v_cnt, bar_pix;
    logic [2:0]  bar_idx;
    logic [1:0]  pat_q, pat_eff;
    logic        h_last, v_last, active, origin, hs_act, vs_act;
    logic [23:0] pix_rgb;

    always_comb begin
        h_last  = (h_cnt == 12'(H_TOTAL - 1));
        v_last  = (v_cnt == 12'(V_TOTAL - 1));
        active  = (h_cnt < 12'(H_ACTIVE)) && (v_cnt < 12'(V_ACTIVE));
        origin  = (h_cnt == 12'd0) && (v_cnt == 12'd0);
        hs_act  = (h_cnt >= 12'(H_ACTIVE + H_FP)) && (h_cnt < 12'(H_ACTIVE + H_FP + H_SYNC));
        vs_act  = (v_cnt >= 12'(V_ACTIVE + V_FP)) && (v_cnt < 12'(V_ACTIVE + V_FP + V_SYNC));
        // The origin pixel already belongs to the frame whose pattern is being latched.
        pat_eff = origin ? pattern_sel : pat_q;
        pix_rgb = 24'h0;
        case (pat_eff)
            2'd0:    pix_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            2'd1:    pix_rgb = {3{h_cnt[7:0]}};
            2'd2:    pix_rgb = (h_cnt[3] ^ v_cnt[3]) ? 24'h0 : 24'hFFFFFF;
            default: pix_rgb = 24'hFFFFFF;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            bar_pix <= '0;
            bar_idx <= '0;
            pat_q   <= '0;
        end else if (enable) begin
            h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
            if (h_last)
                v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
            // Bar index tracks h_cnt without a divider; beyond the active area it is don't-care.
            if (h_last) begin
                bar_pix <= '0;
                bar_idx <= '0;
            end else if (bar_pix == 12'(BAR_W - 1)) begin
                bar_pix <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pix <= bar_pix + 12'd1;
            end
            if (origin)
                pat_q <= pattern_sel;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            den         <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else if (!enable) begin
            den         <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            den         <= active;
            hsync       <= hs_act ? HS_POL : ~HS_POL;
            vsync       <= vs_act ? VS_POL : ~VS_POL;
            frame_start <= active && origin;
            x           <= active ? h_cnt : 12'd0;
            y           <= active ? v_cnt : 12'd0;
            red         <= active ? pix_rgb[23:16] : 8'd0;
            green       <= active ? pix_rgb[15:8]  : 8'd0;
            blue        <= active ? pix_rgb[7:0]   : 8'd0;
        end
    end

endmodule

// File: tb/tb_dvi_tx_video_timing_gen.sv
// Bench for dvi_tx_video_timing_gen with a 16x8 raster: reference-model scoreboard plus directed checks.
module tb_dvi_tx_video_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        den, hsync, vsync, frame_start;
    logic [11:0] x, y;
    logic [7:0]  red, green, blue;
    logic [51:0] outs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dvi_tx_video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
        .den(den), .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
        .x(x), .y(y), .red(red), .green(green), .blue(blue)
    );

    assign outs = {den, hsync, vsync, frame_start, x, y, red, green, blue};

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [51:0] model(input int h, input int v, input logic [1:0] p, input logic en);
        logic act, hs, vs, fs;
        logic [11:0] xx, yy;
        logic [23:0] c;
        if (!en) return '0;
        act = (h < HA) && (v < VA);
        hs  = (h >= HA + HF) && (h < HA + HF + HS);
        vs  = (v >= VA + VF) && (v < VA + VF + VS);
        fs  = act && (h == 0) && (v == 0);
        xx  = act ? 12'(h) : 12'd0;
        yy  = act ? 12'(v) : 12'd0;
        c   = 24'h0;
        if (act) begin
            case (p)
                2'd0:    c = bar_rgb(h / (HA / 8));
                2'd1:    c = {3{xx[7:0]}};
                2'd2:    c = (xx[3] ^ yy[3]) ? 24'h0 : 24'hFFFFFF;
                default: c = 24'hFFFFFF;
            endcase
        end
        return {act, hs, vs, fs, xx, yy, c};
    endfunction

    // Reference model: push the expected output of every clock edge, compare on the falling edge.
    logic [51:0] exp_q[$];
    int          mh = 0, mv = 0;
    logic [1:0]  mpat = 2'd0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mh   <= 0;
            mv   <= 0;
            mpat <= 2'd0;
            exp_q.delete();
        end else begin
            exp_q.push_back(model(mh, mv, (mh == 0 && mv == 0) ? pattern_sel : mpat, enable));
            if (enable) begin
                mh <= (mh == HT - 1) ? 0 : mh + 1;
                if (mh == HT - 1) mv <= (mv == VT - 1) ? 0 : mv + 1;
                if (mh == 0 && mv == 0) mpat <= pattern_sel;
            end
        end
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset_n)
            chk("sb_reset", 64'(outs), 64'h0);
        else if (exp_q.size() > 0)
            chk("sb_pixel", 64'(outs), 64'(exp_q.pop_front()));
    end

    task automatic wait_fs(output int c);
        bit ok = 1'b0;
        c = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (frame_start) begin ok = 1'b1; c = cyc; break; end
        end
        if (!ok) chk("wait_fs_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_pix(input int tx, input int ty);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (den && x == 12'(tx) && y == 12'(ty)) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        if (!ok) chk("wait_pix_timeout", 64'd0, 64'd1);
    endtask

    // Called while sampling the first pixel of a frame; ends on the next frame's first pixel.
    task automatic check_frame();
        int dc = 0, hb = 0, vc = 0, vb = 0, fx = 0;
        chk("first_den", 64'(den), 64'd1);
        chk("first_fs", 64'(frame_start), 64'd1);
        chk("first_xy", 64'({x, y}), 64'd0);
        for (int i = 0; i < HT * VT; i++) begin
            if (i > 0) @(negedge clock);
            dc += int'(den);
            vc += int'(vsync);
            if (hsync != ((i % HT) >= 10 && (i % HT) <= 12)) hb++;
            if (vsync != (i >= 80 && i < 112)) vb++;
            if (i > 0 && frame_start) fx++;
        end
        @(negedge clock);
        chk("fs_period_128", 64'(frame_start), 64'd1);
        chk("den_count", 64'(dc), 64'd32);
        chk("hsync_pos", 64'(hb), 64'd0);
        chk("vsync_count", 64'(vc), 64'd32);
        chk("vsync_pos", 64'(vb), 64'd0);
        chk("fs_extra", 64'(fx), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  pat;
        int          px;
        int          py;
        logic [23:0] rgb;
    } vec_t;

    initial begin
        vec_t vecs[9];
        int   c0, c1, bad;

        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   c0, c1, bad;
        vecs[0] = '{2'd0, 0, 0, 24'hFFFFFF};
        vecs[1] = '{2'd0, 1, 0, 24'hFFFF00};
        vecs[2] = '{2'd0, 7, 0, 24'h000000};
        vecs[3] = '{2'd0, 2, 1, 24'h00FFFF};
        vecs[4] = '{2'd0, 6, 3, 24'h0000FF};
        vecs[5] = '{2'd1, 5, 0, 24'h050505};
        vecs[6] = '{2'd1, 7, 3, 24'h070707};
        vecs[7] = '{2'd2, 3, 2, 24'hFFFFFF};
        vecs[8] = '{2'd3, 4, 3, 24'hFFFFFF};

        reset_n = 1'b0;
        enable = 1'b1;
        pattern_sel = 2'd0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", 64'(outs), 64'h0);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check_frame();

        // Patterns: set selection, it takes effect at the next frame start.
        foreach (vecs[i]) begin
            pattern_sel = vecs[i].pat;
            wait_fs(c0);
            wait_pix(vecs[i].px, vecs[i].py);
            chk($sformatf("pattern_vec%0d", i), 64'({red, green, blue}), 64'(vecs[i].rgb));
        end

        // Mid-frame pattern change holds until the frame boundary.
        pattern_sel = 2'd0;
        wait_fs(c0);
        wait_pix(2, 0);
        pattern_sel = 2'd1;
        wait_pix(5, 1);
        chk("midframe_bars", 64'({red, green, blue}), 64'hFF0000);
        wait_fs(c0);
        wait_pix(5, 0);
        chk("next_frame_ramp", 64'({red, green, blue}), 64'h050505);

        // Pause 20 clocks right after pixel x=3.
        wait_fs(c0);
        wait_pix(3, 1);
        enable = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (den || hsync || vsync || frame_start || ({red, green, blue} != 24'h0)) bad++;
        end
        chk("pause_idle", 64'(bad), 64'd0);
        enable = 1'b1;
        @(negedge clock);
        chk("resume_den", 64'(den), 64'd1);
        chk("resume_x4", 64'(x), 64'd4);
        wait_fs(c1);
        chk("paused_frame_len", 64'(c1 - c0), 64'd148);

        // Asynchronous reset between clock edges.
        pattern_sel = 2'd2;
        wait_pix(2, 2);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1 chk("async_reset_outputs", 64'(outs), 64'h0);
        pattern_sel = 2'd0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
